// File: rtl/env_scan_reader_if.sv
// Bus bundle for env_scan_reader.
//   master (reader side): drives memory read request and pixel stream, samples rd_data/pix_ready.
//   slave  (RAM + consumer side): returns rd_data, applies pix_ready.
//   rd_en/rd_x/rd_y : read strobe and raster address
//   rd_data         : cell data returned a fixed latency after rd_en
//   pix_valid/pix_ready/pix_data/pix_x/pix_y : valid/ready cell stream with coordinates
interface env_scan_reader_if #(
  parameter int unsigned X_bits = 10,
  parameter int unsigned Y_bits = 9,
  parameter int unsigned DATA_W = 8
);
  logic              rd_en;
  logic [X_bits-1:0] rd_x;
  logic [Y_bits-1:0] rd_y;
  logic [DATA_W-1:0] rd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [X_bits-1:0] pix_x;
  logic [Y_bits-1:0] pix_y;

  modport master (
    output rd_en, rd_x, rd_y,
    input  rd_data,
    output pix_valid, pix_data, pix_x, pix_y,
    input  pix_ready
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    output rd_data,
    input  pix_valid, pix_data, pix_x, pix_y,
    output pix_ready
  );
endinterface

// File: rtl/env_scan_reader.sv
// Raster-order read scanner for the environment store. Issues fixed-latency reads under a
// credit limit, tags returns with their (x,y), buffers them in a small FIFO and streams cells
// to the display pipeline over valid/ready.
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   frame_start_i : 1-cycle pulse starting a frame pass (only honoured when idle)
//   busy_o        : high whenever not idle
//   frame_done_o  : 1-cycle pulse once the last cell of the frame has been accepted
//   bus           : memory read request/return and pixel stream (master side)
module env_scan_reader #(
  parameter int unsigned X_bits   = 10,
  parameter int unsigned Y_bits   = 9,
  parameter int unsigned PIXELS_X = 640,
  parameter int unsigned PIXELS_Y = 480,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start_i,
  output logic                busy_o,
  output logic                frame_done_o,
  env_scan_reader_if.master   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(RD_LAT + 1);
  localparam int unsigned OCC_W = $clog2(DEPTH + RD_LAT + 2) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [X_bits-1:0] x;
    logic [Y_bits-1:0] y;
  } cell_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [X_bits-1:0] x_q, x_d;
  logic [Y_bits-1:0] y_q, y_d;
  logic              rd_en_q, rd_en_d;
  logic [X_bits-1:0] rd_x_q, rd_x_d;
  logic [Y_bits-1:0] rd_y_q, rd_y_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [RD_LAT-1:0] stg_v_q;
  logic [X_bits-1:0] stg_x_q [RD_LAT];
  logic [Y_bits-1:0] stg_y_q [RD_LAT];
  logic [INF_W-1:0]  inflight_q, inflight_d;

  cell_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  cell_t             head;

  logic              push, pop, issue, last_cell, last_col, credit_ok, drained;
  logic [OCC_W-1:0]  occ;

  assign push = stg_v_q[RD_LAT-1];
  assign pop  = (count_q != '0) && bus.pix_ready;

  // Occupancy the FIFO would reach next cycle without a new read: buffered cells minus this
  // cycle's pop, plus everything already requested (read strobe out now and tags in flight).
  assign occ = OCC_W'(count_q) + OCC_W'(inflight_q) + OCC_W'(rd_en_q) - OCC_W'(pop);
  assign credit_ok = occ < OCC_W'(DEPTH);

  assign last_col  = (x_q == X_bits'(PIXELS_X - 1));
  assign last_cell = last_col && (y_q == Y_bits'(PIXELS_Y - 1));
  assign drained   = (count_q == '0) && (inflight_q == '0) && !rd_en_q;

  // Next-state, read issue and scan advance
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rd_en_d = 1'b0;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          issue   = 1'b1;
          state_d = last_cell ? S_DRAIN : S_SCAN;
        end
      end
      S_SCAN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (last_cell) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      rd_en_d = 1'b1;
      rd_x_d  = x_q;
      rd_y_d  = y_q;
      if (last_col) begin
        x_d = '0;
        y_d = last_cell ? '0 : y_q + Y_bits'(1);
      end else begin
        x_d = x_q + X_bits'(1);
      end
    end
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
  end

  // FSM, scan position and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      rd_en_q      <= 1'b0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rd_en_q      <= rd_en_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign inflight_d = inflight_q + INF_W'(rd_en_q) - INF_W'(push);

  // Tag pipeline: exits in the same cycle the memory presents the matching rd_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v_q    <= '0;
      inflight_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stg_x_q[i] <= '0;
        stg_y_q[i] <= '0;
      end
    end else begin
      stg_v_q[0] <= rd_en_q;
      stg_x_q[0] <= rd_x_q;
      stg_y_q[0] <= rd_y_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stg_v_q[i] <= stg_v_q[i-1];
        stg_x_q[i] <= stg_x_q[i-1];
        stg_y_q[i] <= stg_y_q[i-1];
      end
      inflight_q <= inflight_d;
    end
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Output FIFO; credit limit keeps pushes away from a full buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{data: bus.rd_data, x: stg_x_q[RD_LAT-1], y: stg_y_q[RD_LAT-1]};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_x      = rd_x_q;
  assign bus.rd_y      = rd_y_q;
  assign bus.pix_valid = (count_q != '0);
  assign bus.pix_data  = head.data;
  assign bus.pix_x     = head.x;
  assign bus.pix_y     = head.y;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;

endmodule
